// File: rtl/shift_ser_ctrl_if.sv
// shift_ser_ctrl_if
// Bundles every signal between the nibble serializer controller, its
// upstream nibble source, the external 4-bit shift register and the
// downstream serial sink.
//   in_valid/in_data/in_dir/in_ready : upstream nibble handshake
//   sr_mode/sr_pin/sr_sin_r/sr_sin_l : control to the shift register
//   sr_q                             : shift register contents
//   ser_ready/ser_out/ser_valid      : downstream serial handshake
//   done                             : one-cycle end-of-frame pulse
// Modport master is the controller; slave is its environment.
interface shift_ser_ctrl_if;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_dir;
    logic       in_ready;
    logic [1:0] sr_mode;
    logic [3:0] sr_pin;
    logic       sr_sin_r;
    logic       sr_sin_l;
    logic [3:0] sr_q;
    logic       ser_ready;
    logic       ser_out;
    logic       ser_valid;
    logic       done;

    modport master (
        input  in_valid, in_data, in_dir, sr_q, ser_ready,
        output in_ready, sr_mode, sr_pin, sr_sin_r, sr_sin_l,
               ser_out, ser_valid, done
    );

    modport slave (
        output in_valid, in_data, in_dir, sr_q, ser_ready,
        input  in_ready, sr_mode, sr_pin, sr_sin_r, sr_sin_l,
               ser_out, ser_valid, done
    );
endinterface

// File: rtl/shift_ser_ctrl.sv
// shift_ser_ctrl
// Accepts a 4-bit nibble, loads it into an external 4-bit shift register
// and streams it out one bit per accepted serial transfer, LSB-first
// (in_dir=0, shift right) or MSB-first (in_dir=1, shift left), then pulses
// done for one cycle.
// Ports:
//   clk  : rising-edge clock
//   clr  : asynchronous active-high reset (shared with the shift register)
//   bus  : shift_ser_ctrl_if.master, all handshake and shift-register signals
// Configuration:
//   PARITY_EN : when defined, an even-parity bit (XOR of the nibble) is
//               sent after the four data bits.
module shift_ser_ctrl (
    input  logic             clk,
    input  logic             clr,
    shift_ser_ctrl_if.master bus
);

`ifdef PARITY_EN
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, PAR, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DONE} state_t;
`endif

    state_t     state;
    state_t     state_nxt;
    logic [3:0] data_r;
    logic       dir_r;
    logic [1:0] bit_cnt;
    logic [1:0] bit_cnt_nxt;
    logic       capture;

    // State, bit counter and the captured nibble/direction. The capture
    // registers are only written on an IDLE accept, so upstream activity
    // during a frame cannot disturb it.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            bit_cnt <= 2'd0;
            data_r  <= 4'd0;
            dir_r   <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            if (capture) begin
                data_r <= bus.in_data;
                dir_r  <= bus.in_dir;
            end
        end
    end

    // Next-state and output decode. ser_out is taken straight from the
    // shift register end that is about to leave; holding the register
    // (mode 00) on a stall therefore also holds ser_out. On the last bit
    // the counter is cleared instead of incremented so it never wraps.
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        capture       = 1'b0;
        bus.in_ready  = 1'b0;
        bus.sr_mode   = 2'b00;
        bus.sr_pin    = 4'b0000;
        bus.sr_sin_r  = 1'b0;
        bus.sr_sin_l  = 1'b0;
        bus.ser_out   = 1'b0;
        bus.ser_valid = 1'b0;
        bus.done      = 1'b0;

        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    capture   = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                bus.sr_mode = 2'b11;
                bus.sr_pin  = data_r;
                bit_cnt_nxt = 2'd0;
                state_nxt   = SHIFT;
            end
            SHIFT: begin
                bus.ser_valid = 1'b1;
                bus.ser_out   = dir_r ? bus.sr_q[3] : bus.sr_q[0];
                if (bus.ser_ready) begin
                    bus.sr_mode = dir_r ? 2'b10 : 2'b01;
                    if (bit_cnt == 2'd3) begin
                        bit_cnt_nxt = 2'd0;
`ifdef PARITY_EN
                        state_nxt   = PAR;
`else
                        state_nxt   = DONE;
`endif
                    end else begin
                        bit_cnt_nxt = bit_cnt + 2'd1;
                    end
                end
            end
`ifdef PARITY_EN
            PAR: begin
                bus.ser_valid = 1'b1;
                bus.ser_out   = ^data_r;
                if (bus.ser_ready) begin
                    state_nxt = DONE;
                end
            end
`endif
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_ser_ctrl.sv
// tb_shift_ser_ctrl
// Drives shift_ser_ctrl with directed frames and random traffic. A
// behavioural shift register closes the loop on sr_q, and a queue-based
// frame model predicts every output each cycle. Honours PARITY_EN when
// defined for the build.
module tb_shift_ser_ctrl;

`ifdef PARITY_EN
    localparam int PAR_LEN = 1;
`else
    localparam int PAR_LEN = 0;
`endif
    localparam int FRAME_PERIOD = 7 + PAR_LEN;

    logic clk;
    logic clr;

    shift_ser_ctrl_if bus ();

    shift_ser_ctrl dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External 4-bit shift register: 01 shifts toward bit 0, 10 toward
    // bit 3, 11 loads, 00 holds.
    logic [3:0] sr_q_r;
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sr_q_r <= 4'd0;
        end else begin
            case (bus.sr_mode)
                2'b01:   sr_q_r <= {bus.sr_sin_r, sr_q_r[3:1]};
                2'b10:   sr_q_r <= {sr_q_r[2:0], bus.sr_sin_l};
                2'b11:   sr_q_r <= bus.sr_pin;
                default: sr_q_r <= sr_q_r;
            endcase
        end
    end
    assign bus.sr_q = sr_q_r;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    // Frame model: idle, a load cycle, a queue of bits still to send,
    // then one done cycle once the queue is empty.
    logic       m_busy = 1'b0;
    logic       m_load = 1'b0;
    logic [3:0] m_nib  = 4'd0;
    logic       m_dir  = 1'b0;
    logic       m_bits[$];
    int         m_done_total = 0;

    int         dut_done_total = 0;
    int         dut_accepts    = 0;
    logic [4:0] obs_stream = 5'd0;
    int         obs_nbits  = 0;
    logic       obs_done   = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_busy = 1'b0;
        m_load = 1'b0;
        m_nib  = 4'd0;
        m_dir  = 1'b0;
        m_bits.delete();
    endtask

    // Expected {in_ready, sr_mode, sr_pin, sr_sin_r, sr_sin_l, ser_out,
    // ser_valid, done} for the current cycle.
    function automatic logic [11:0] modelOut(input logic rdy);
        logic [1:0] mode;
        if (!m_busy) return {1'b1, 2'b00, 4'b0000, 5'b00000};
        if (m_load)  return {1'b0, 2'b11, m_nib, 5'b00000};
        if (m_bits.size() > 0) begin
            if (!rdy)
                mode = 2'b00;
            else if (PAR_LEN == 1 && m_bits.size() == 1)
                mode = 2'b00;
            else
                mode = m_dir ? 2'b10 : 2'b01;
            return {1'b0, mode, 4'b0000, 1'b0, 1'b0, m_bits[0], 1'b1, 1'b0};
        end
        return {1'b0, 2'b00, 4'b0000, 5'b00001};
    endfunction

    task automatic modelStep(input logic v, input logic [3:0] d, input logic dr,
                             input logic rdy);
        if (!m_busy) begin
            if (v) begin
                m_busy = 1'b1;
                m_load = 1'b1;
                m_nib  = d;
                m_dir  = dr;
                m_bits.delete();
                for (int i = 0; i < 4; i++) m_bits.push_back(dr ? d[3-i] : d[i]);
                if (PAR_LEN == 1) m_bits.push_back(^d);
            end
        end else if (m_load) begin
            m_load = 1'b0;
        end else if (m_bits.size() > 0) begin
            if (rdy) void'(m_bits.pop_front());
        end else begin
            m_busy = 1'b0;
            m_done_total++;
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare every
    // output against the model, record observations, advance the model.
    task automatic applyStimulus(input logic v, input logic [3:0] d, input logic dr,
                                 input logic rdy, input logic rst);
        logic [11:0] got;
        logic [11:0] exp_v;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_dir    = dr;
        bus.ser_ready = rdy;
        clr           = rst;
        #1;
        if (rst) modelReset();
        got = {bus.in_ready, bus.sr_mode, bus.sr_pin, bus.sr_sin_r, bus.sr_sin_l,
               bus.ser_out, bus.ser_valid, bus.done};
        exp_v = modelOut(rdy);
        checkOutput($sformatf("outputs@%0d", cycle), 32'(got), 32'(exp_v));
        if (bus.ser_valid && rdy) begin
            obs_stream = {obs_stream[3:0], bus.ser_out};
            obs_nbits++;
        end
        if (bus.done) begin
            obs_done = 1'b1;
            dut_done_total++;
        end
        if (bus.in_valid && bus.in_ready) dut_accepts++;
        if (!rst) modelStep(v, d, dr, rdy);
        cycle++;
    endtask

    // Sends one frame from IDLE with optional stall while bit stall_bit is
    // on the line, then checks the bit stream and done latency.
    task automatic runFrame(input string tag, input logic [3:0] d, input logic dr,
                            input int stall_bit, input int stall_len);
        int         accept_cyc;
        int         done_cyc;
        int         stalls;
        int         guard;
        int         c;
        logic       rdy;
        logic [3:0] exp_data;
        logic [4:0] exp_stream;
        obs_stream = 5'd0;
        obs_nbits  = 0;
        obs_done   = 1'b0;
        stalls     = 0;
        guard      = 0;
        done_cyc   = -1;
        for (int i = 0; i < 4; i++) exp_data[3-i] = dr ? d[3-i] : d[i];
        exp_stream = (PAR_LEN == 1) ? {exp_data, ^d} : {1'b0, exp_data};
        accept_cyc = cycle;
        applyStimulus(1'b1, d, dr, 1'b1, 1'b0);
        while (!obs_done && guard < 40) begin
            rdy = 1'b1;
            if (obs_nbits == stall_bit && stalls < stall_len) begin
                rdy = 1'b0;
                stalls++;
            end
            c = cycle;
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), rdy, 1'b0);
            if (obs_done) done_cyc = c;
            guard++;
        end
        checkOutput({tag, "_done_seen"}, 32'(obs_done), 32'd1);
        checkOutput({tag, "_bits"}, 32'(obs_stream), 32'(exp_stream));
        checkOutput({tag, "_latency"}, 32'(done_cyc - accept_cyc),
                    32'(6 + PAR_LEN + stall_len));
    endtask

    initial begin
        int done_before;
        int acc_before;
        clr           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'd0;
        bus.in_dir    = 1'b0;
        bus.ser_ready = 1'b0;

        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);

        runFrame("lsb_1011", 4'b1011, 1'b0, -1, 0);
        runFrame("msb_1011", 4'b1011, 1'b1, -1, 0);
        runFrame("stall_0110", 4'b0110, 1'b0, 1, 2);
        runFrame("par_0111", 4'b0111, 1'b0, -1, 0);
        runFrame("par_0101", 4'b0101, 1'b1, 2, 1);

        // Abort a frame while bit 2 is on the line.
        done_before = dut_done_total;
        applyStimulus(1'b1, 4'b1101, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("clr_no_done", 32'(dut_done_total - done_before), 32'd0);
        checkOutput("clr_sr_q", 32'(sr_q_r), 32'd0);
        runFrame("after_clr_1000", 4'b1000, 1'b0, -1, 0);

        // in_valid held high: accepts only from IDLE, one per frame period.
        acc_before = dut_accepts;
        for (int i = 0; i < 70; i++)
            applyStimulus(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          1'b1, 1'b0);
        checkOutput("continuous_accepts", 32'(dut_accepts - acc_before),
                    32'((70 + FRAME_PERIOD - 1) / FRAME_PERIOD));

        for (int i = 0; i < 400; i++)
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'b0);
        for (int i = 0; i < 20; i++)
            applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("done_total", 32'(dut_done_total), 32'(m_done_total));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/shift_ser_ctrl.md
SHIFT_SER_CTRL -- requirements
Module: shift_ser_ctrl

Interface
REQ-001 SHALL provide ports: clk input 1, rising-edge clock; clr input 1, reset, asynchronous, active-high.
REQ-002 SHALL provide in_valid input 1 (upstream nibble valid), in_data input 4 (nibble to send) and in_dir input 1 (0 = LSB-first/shift right, 1 = MSB-first/shift left).
REQ-003 SHALL provide in_ready output 1, meaning the controller accepts a nibble this cycle.
REQ-004 SHALL provide sr_mode output 2, the mode to the 4-bit shift register (00 hold, 01 right, 10 left, 11 load).
REQ-005 SHALL provide sr_pin output 4 (parallel load value), and sr_sin_r and sr_sin_l outputs 1 each (serial fill bits, always 0).
REQ-006 SHALL provide sr_q input 4, the current shift-register contents.
REQ-007 SHALL provide ser_ready input 1, meaning the downstream sink accepts a bit.
REQ-008 SHALL provide ser_out output 1 (serial bit), ser_valid output 1 (ser_out is valid) and done output 1 (one-cycle end-of-frame pulse).

Function
REQ-009 SHALL implement the states IDLE, LOAD, SHIFT, PAR (only with macro) and DONE, all registered.
REQ-010 In IDLE: in_ready=1 and sr_mode=00; when in_valid=1, SHALL capture in_data and in_dir into internal registers and go to LOAD.
REQ-011 In LOAD: in_ready=0, sr_mode=11 and sr_pin=captured data; SHALL go to SHIFT with bit_cnt=0 in the next cycle.
REQ-012 In SHIFT: ser_valid=1; ser_out SHALL be sr_q[0] when dir=0 and sr_q[3] when dir=1.
REQ-013 In SHIFT with ser_ready=1: sr_mode SHALL be 01 (dir=0) or 10 (dir=1) and bit_cnt SHALL increment.
REQ-014 In SHIFT with ser_ready=0: sr_mode SHALL be 00, and bit_cnt and ser_out SHALL be held (stall).
REQ-015 After the transfer with bit_cnt=3 completes, SHALL go to PAR if PARITY_EN is defined, otherwise to DONE.
REQ-016 In DONE: done=1 and ser_valid=0 for exactly one cycle, then return to IDLE; in_ready SHALL stay 0 in DONE (no back-to-back accept).
REQ-017 Latency, no stalls, no parity: accept at cycle N; LOAD at N+1; bits at N+2..N+5; done at N+6; next accept possible at N+7.
REQ-018 In all states except LOAD, sr_pin SHALL be 0000.
REQ-019 in_valid, in_data and in_dir SHALL be ignored outside IDLE.
REQ-020 bit_cnt SHALL be 2 bits wide and SHALL never wrap while in SHIFT.

Reset
REQ-021 On clr=1, SHALL go immediately to IDLE with: in_ready=1, sr_mode=00, sr_pin=0000, ser_out=0, ser_valid=0, done=0, bit_cnt=0, captured data=0, dir=0.
REQ-022 clr asserted mid-frame SHALL abort the frame with no done pulse; the shift register shares the same clr.
REQ-023 After clr deasserts, the first rising edge SHALL be able to accept a nibble.

Configuration
REQ-024 Macro PARITY_EN defined: the PAR state SHALL exist.
REQ-025 In PAR: ser_valid=1, ser_out=XOR of the captured nibble (even parity), sr_mode=00; SHALL go to DONE on ser_ready=1 and hold otherwise.
REQ-026 With PARITY_EN defined, the unstalled done pulse SHALL be at N+7.
REQ-027 Macro PARITY_EN undefined: PAR SHALL be absent and the frame SHALL be 4 bits.

Verification
REQ-028 Reset, then in_data=1011, dir=0, ser_ready=1 -> ser_out sequence 1,1,0,1 at N+2..N+5, done at N+6, sr_mode 11 then 01 x4.
REQ-029 in_data=1011, dir=1 -> ser_out 1,0,1,1 with sr_mode=10 during the shifts.
REQ-030 dir=0, data=0110, ser_ready low for 2 cycles during bit 1 -> ser_out=1 held, sr_mode=00 during the stall, bit stream 0,1,1,0, done delayed by 2 cycles.
REQ-031 PARITY_EN defined, data=0111 -> 4 data bits then parity bit 1, done at N+7; data=0101 -> parity bit 0.
REQ-032 clr pulsed during bit 2 -> all outputs at reset values the same cycle, no done, next frame 1000 sent correctly.
REQ-033 in_valid held high continuously -> a new accept occurs only in IDLE, one per 7 cycles (8 with parity); in_data changes mid-frame do not affect ser_out.
